// File: rtl/id_dispatch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : id_dispatch_queue_if
// Description : Decode-side push and rename-side pop signals of the dispatch queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_dispatch_queue_if #(
    parameter int CONFIG_P_ISSUE_WIDTH = 2,
    parameter int CONFIG_P_RN_WIDTH    = 1,
    parameter int CONFIG_P_DEPTH       = 3,
    parameter int PAYLOAD_W            = 64
);
    logic                                             flush;
    logic [(1<<CONFIG_P_ISSUE_WIDTH)-1:0]             id_valid;
    logic [PAYLOAD_W*(1<<CONFIG_P_ISSUE_WIDTH)-1:0]   id_payload;
    logic [CONFIG_P_ISSUE_WIDTH:0]                    id_pop_cnt;
    logic [(1<<CONFIG_P_RN_WIDTH)-1:0]                rn_valid;
    logic [PAYLOAD_W*(1<<CONFIG_P_RN_WIDTH)-1:0]      rn_payload;
    logic [CONFIG_P_RN_WIDTH:0]                       rn_pop_cnt;
    logic [CONFIG_P_DEPTH:0]                          free_cnt;

    modport master (
        output flush, id_valid, id_payload, rn_pop_cnt,
        input  id_pop_cnt, rn_valid, rn_payload, free_cnt
    );

    modport slave (
        input  flush, id_valid, id_payload, rn_pop_cnt,
        output id_pop_cnt, rn_valid, rn_payload, free_cnt
    );
endinterface
`default_nettype wire

// File: rtl/id_dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module      : id_dispatch_queue
// Description : Compacting circular queue between decode and rename.
// Revision    : 1.0 - initial release
// ============================================================================
module id_dispatch_queue #(
    parameter int CONFIG_P_ISSUE_WIDTH = 2,
    parameter int CONFIG_P_RN_WIDTH    = 1,
    parameter int CONFIG_P_DEPTH       = 3,
    parameter int PAYLOAD_W            = 64
) (
    input  wire logic          clk,
    input  wire logic          rst,
    id_dispatch_queue_if.slave bus
);
    localparam int c_iw = 1 << CONFIG_P_ISSUE_WIDTH;
    localparam int c_ow = 1 << CONFIG_P_RN_WIDTH;
    localparam int c_d  = 1 << CONFIG_P_DEPTH;
    localparam int c_pw = CONFIG_P_DEPTH;
    localparam int c_cw = CONFIG_P_DEPTH + 1;
    localparam logic [c_cw-1:0] c_d_cnt  = c_cw'(c_d);
    localparam logic [c_cw-1:0] c_ow_cnt = c_cw'(c_ow);

    logic [PAYLOAD_W-1:0] r_mem [c_d];
    logic [c_pw-1:0]      r_head;
    logic [c_pw-1:0]      r_tail;
    logic [c_cw-1:0]      r_count;

    logic [c_cw-1:0]      w_free;
    logic [c_cw-1:0]      w_n;
    logic [c_cw-1:0]      w_push;
    logic [c_cw-1:0]      w_pop;
    logic [c_cw-1:0]      w_req;
    logic [c_cw-1:0]      w_avail;
    logic                 w_push_ok;
    logic [c_pw-1:0]      w_waddr [c_iw];

    // Each valid lane lands at tail plus the number of valid lanes below it,
    // which squeezes out the holes in id_valid.
    always_comb begin
        w_free = c_d_cnt - r_count;
        w_n    = '0;
        for (int i = 0; i < c_iw; i++) begin
            w_waddr[i] = r_tail + w_n[c_pw-1:0];
            w_n        = w_n + c_cw'(bus.id_valid[i]);
        end
        // All-or-nothing, judged against registered count only so that
        // rename's pop never feeds back into decode in the same cycle.
        w_push_ok      = !rst && !bus.flush && (w_n <= w_free);
        w_push         = w_push_ok ? w_n : '0;
        bus.id_pop_cnt = w_push[CONFIG_P_ISSUE_WIDTH:0];
        w_req          = c_cw'(bus.rn_pop_cnt);
        w_pop          = (w_req < r_count) ? w_req : r_count;
        w_avail        = (r_count < c_ow_cnt) ? r_count : c_ow_cnt;
        bus.free_cnt   = w_free;
    end

    always_comb begin
        bus.rn_valid   = '0;
        bus.rn_payload = '0;
        for (int k = 0; k < c_ow; k++) begin
            bus.rn_valid[k]                          = (r_count > c_cw'(k));
            bus.rn_payload[k*PAYLOAD_W +: PAYLOAD_W] = r_mem[r_head + c_pw'(k)];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + w_pop[c_pw-1:0];
            r_tail  <= r_tail + w_push[c_pw-1:0];
            r_count <= r_count + w_push - w_pop;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            for (int i = 0; i < c_iw; i++) begin
                if (bus.id_valid[i]) begin
                    r_mem[w_waddr[i]] <= bus.id_payload[i*PAYLOAD_W +: PAYLOAD_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!bus.flush) begin
                assert (w_req <= w_avail);
            end
            assert (r_count <= c_d_cnt);
            assert ((bus.rn_valid & (bus.rn_valid + c_ow'(1))) == '0);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_id_dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_dispatch_queue
// Description : Directed and random stimulus against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_dispatch_queue;
    localparam int c_depth = 8;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    logic [7:0] q_model [$];

    always #5 clk = ~clk;

    id_dispatch_queue_if #(
        .CONFIG_P_ISSUE_WIDTH(2), .CONFIG_P_RN_WIDTH(1),
        .CONFIG_P_DEPTH(3), .PAYLOAD_W(8)
    ) bus ();

    id_dispatch_queue #(
        .CONFIG_P_ISSUE_WIDTH(2), .CONFIG_P_RN_WIDTH(1),
        .CONFIG_P_DEPTH(3), .PAYLOAD_W(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check accept count, advance model, check registered outputs.
    task automatic cycle(input logic [3:0] v, input logic [31:0] pl,
                         input logic [1:0] pop, input logic fl, input logic rs);
        int n;
        int exp_push;
        int p;
        int sz;
        logic [31:0] plv;
        plv = pl;
        bus.id_valid   = v;
        bus.id_payload = pl;
        bus.rn_pop_cnt = pop;
        bus.flush      = fl;
        rst            = rs;
        #1;
        n = $countones(v);
        exp_push = (!rs && !fl && (n <= c_depth - q_model.size())) ? n : 0;
        chk("id_pop_cnt", 32'(bus.id_pop_cnt), 32'(exp_push));
        @(posedge clk);
        if (rs || fl) begin
            q_model.delete();
        end else begin
            p = (int'(pop) < q_model.size()) ? int'(pop) : q_model.size();
            for (int i = 0; i < p; i++) void'(q_model.pop_front());
            if (exp_push != 0) begin
                for (int i = 0; i < 4; i++)
                    if (v[i]) q_model.push_back(plv[i*8 +: 8]);
            end
        end
        @(negedge clk);
        sz = q_model.size();
        chk("free_cnt", 32'(bus.free_cnt), 32'(c_depth - sz));
        chk("rn_valid", 32'(bus.rn_valid), {30'd0, sz > 1, sz > 0});
        for (int k = 0; k < 2; k++)
            if (k < sz) chk($sformatf("rn_payload%0d", k), 32'(bus.rn_payload[k*8 +: 8]), 32'(q_model[k]));
    endtask

    initial begin
        int sz;
        logic [1:0] pop;
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.id_valid = '0;
        bus.id_payload = '0;
        bus.rn_pop_cnt = '0;

        cycle(4'b0000, 32'h0, 2'd0, 1'b0, 1'b1);
        cycle(4'b0000, 32'h0, 2'd0, 1'b0, 1'b1);
        // Holes in id_valid are compacted
        cycle(4'b1011, 32'hA3A2A1A0, 2'd0, 1'b0, 1'b0);
        cycle(4'b0000, 32'h0, 2'd2, 1'b0, 1'b0);
        cycle(4'b0000, 32'h0, 2'd1, 1'b0, 1'b0);
        // Full-refusal: count 6 plus four lanes refused despite same-cycle pop
        cycle(4'b1111, 32'h23222120, 2'd0, 1'b0, 1'b0);
        cycle(4'b0011, 32'h00003130, 2'd0, 1'b0, 1'b0);
        cycle(4'b1111, 32'h43424140, 2'd2, 1'b0, 1'b0);
        cycle(4'b1111, 32'h43424140, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(4'b0000, 32'h0, 2'd2, 1'b0, 1'b0);
        // Bring head and tail to 6, then push across the wrap
        cycle(4'b0001, 32'h0000005A, 2'd0, 1'b0, 1'b0);
        cycle(4'b0000, 32'h0, 2'd1, 1'b0, 1'b0);
        cycle(4'b1111, 32'h13121110, 2'd0, 1'b0, 1'b0);
        cycle(4'b0000, 32'h0, 2'd2, 1'b0, 1'b0);
        cycle(4'b0000, 32'h0, 2'd2, 1'b0, 1'b0);
        // Flush drops contents and the concurrent push
        cycle(4'b1111, 32'h63626160, 2'd0, 1'b0, 1'b0);
        cycle(4'b0001, 32'h00000064, 2'd0, 1'b0, 1'b0);
        cycle(4'b1111, 32'h73727170, 2'd2, 1'b1, 1'b0);
        cycle(4'b0001, 32'h00000055, 2'd0, 1'b0, 1'b0);
        cycle(4'b0110, 32'h00776600, 2'd1, 1'b0, 1'b0);
        // Mid-stream reset at count 7
        cycle(4'b1111, 32'h83828180, 2'd0, 1'b0, 1'b0);
        cycle(4'b0001, 32'h00000084, 2'd0, 1'b0, 1'b0);
        cycle(4'b1111, 32'h93929190, 2'd0, 1'b0, 1'b1);
        cycle(4'b0000, 32'h0, 2'd0, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            sz  = q_model.size();
            pop = 2'($urandom_range(0, (sz < 2) ? sz : 2));
            cycle(4'($urandom), $urandom, pop,
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
